// File: rtl/crc_serial_engine.sv
// Bit-serial MSB-first CRC engine with a valid/ready word input and a per-message crc_valid pulse.
// Optional CRC_SD_TOKEN_EN adds the SD trailer token output {crc, end bit}.
module crc_serial_engine #(
  parameter int                DATA_W   = 8,
  parameter int                CRC_W    = 7,
  parameter logic [CRC_W-1:0]  POLY     = 'h09,
  parameter logic [CRC_W-1:0]  CRC_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_valid,
  output logic              busy
`ifdef CRC_SD_TOKEN_EN
  ,
  output logic [CRC_W:0]    crc_token,
  output logic              crc_token_valid
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [CRC_W-1:0]   crc, crc_next;
  logic [DATA_W-1:0]  shreg, shreg_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               last_flag, last_next;
  logic               in_msg, in_msg_next;
  logic               fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= CRC_INIT;
      shreg     <= '0;
      cnt       <= '0;
      last_flag <= 1'b0;
      in_msg    <= 1'b0;
    end else begin
      state     <= state_next;
      crc       <= crc_next;
      shreg     <= shreg_next;
      cnt       <= cnt_next;
      last_flag <= last_next;
      in_msg    <= in_msg_next;
    end
  end

  // clear overrides everything; a word is only taken in IDLE when clear is low.
  always_comb begin
    state_next  = state;
    crc_next    = crc;
    shreg_next  = shreg;
    cnt_next    = cnt;
    last_next   = last_flag;
    in_msg_next = in_msg;
    fb          = 1'b0;
    if (clear) begin
      state_next  = IDLE;
      crc_next    = CRC_INIT;
      cnt_next    = '0;
      last_next   = 1'b0;
      in_msg_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg_next = in_data;
            last_next  = in_last;
            cnt_next   = CNT_W'(DATA_W);
            state_next = SHIFT;
            if (!in_msg) begin
              crc_next    = CRC_INIT;
              in_msg_next = 1'b1;
            end
          end
        end
        SHIFT: begin
          fb         = crc[CRC_W-1] ^ shreg[DATA_W-1];
          crc_next   = {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
          shreg_next = shreg << 1;
          cnt_next   = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state_next = last_flag ? DONE : IDLE;
          end
        end
        DONE: begin
          in_msg_next = 1'b0;
          state_next  = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !clear;
  assign crc_valid = (state == DONE) && !clear;
  assign busy      = (state != IDLE) || in_msg;
  assign crc_out   = crc;

`ifdef CRC_SD_TOKEN_EN
  assign crc_token       = {crc, 1'b1};
  assign crc_token_valid = crc_valid;
`endif

endmodule

// File: tb/tb_crc_serial_engine.sv
// Self-checking bench: CRC7 and CRC16-CCITT engine instances sharing one stimulus path,
// known SD vectors in a table, handshake timing, abort/reset corners, and randomized messages vs a long-division model.
module tb_crc_serial_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        sel16;

  logic        ready7, ready16, cvalid7, cvalid16, busy7, busy16;
  logic [6:0]  crc7;
  logic [15:0] crc16;
`ifdef CRC_SD_TOKEN_EN
  logic [7:0]  token7;
  logic        tvalid7;
  logic [16:0] token16;
  logic        tvalid16;
`endif

  logic        in_ready_s, crc_valid_s, busy_s;
  logic [15:0] crc_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] vq[$];
  int          vcyc[$];
  int          acc[$];

  always #5 clk = ~clk;

  crc_serial_engine #(.DATA_W(8), .CRC_W(7), .POLY(7'h09), .CRC_INIT(7'h00)) dut7 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid && !sel16), .in_ready(ready7),
    .in_data(in_data), .in_last(in_last),
    .crc_out(crc7), .crc_valid(cvalid7), .busy(busy7)
`ifdef CRC_SD_TOKEN_EN
    , .crc_token(token7), .crc_token_valid(tvalid7)
`endif
  );

  crc_serial_engine #(.DATA_W(8), .CRC_W(16), .POLY(16'h1021), .CRC_INIT(16'h0000)) dut16 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid && sel16), .in_ready(ready16),
    .in_data(in_data), .in_last(in_last),
    .crc_out(crc16), .crc_valid(cvalid16), .busy(busy16)
`ifdef CRC_SD_TOKEN_EN
    , .crc_token(token16), .crc_token_valid(tvalid16)
`endif
  );

  assign in_ready_s  = sel16 ? ready16  : ready7;
  assign crc_valid_s = sel16 ? cvalid16 : cvalid7;
  assign busy_s      = sel16 ? busy16   : busy7;
  assign crc_s       = sel16 ? crc16    : {9'b0, crc7};

  always @(posedge clk) cyc <= cyc + 1;

  // Pulses are logged mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (crc_valid_s) begin
      vq.push_back(crc_s);
      vcyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [7:0]  b [5];
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [5];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one word (called just after a falling edge) and hold it until accepted.
  task automatic apply_stimulus(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready_s && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (!in_ready_s) check_output("accept_timeout", 32'(in_ready_s), 32'd1);
    acc.push_back(cyc);
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] msg[$], input bit gap);
    foreach (msg[i]) begin
      apply_stimulus(msg[i], i == msg.size() - 1);
      if (gap) begin
        @(negedge clk); #1;
      end
    end
  endtask

  task automatic wait_pulses(input int n);
    int k = 0;
    while (vq.size() < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    repeat (3) begin
      @(negedge clk); #1;
    end
    check_output("pulse_count", 32'(vq.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #12;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
  endtask

  // Polynomial long division of M(x)*x^w by the full generator.
  function automatic logic [15:0] model_crc(input logic [7:0] msg[$], input int w, input logic [15:0] poly);
    bit          m[$];
    logic [16:0] gen;
    logic [15:0] rem;
    gen = 17'(poly) | (17'd1 << w);
    foreach (msg[i]) for (int k = 7; k >= 0; k--) m.push_back(msg[i][k]);
    for (int k = 0; k < w; k++) m.push_back(1'b0);
    for (int i = 0; i + w < m.size(); i++) begin
      if (m[i]) for (int j = 0; j <= w; j++) m[i+j] ^= gen[w-j];
    end
    rem = '0;
    for (int j = 0; j < w; j++) rem = {rem[14:0], m[m.size()-w+j]};
    return rem;
  endfunction

  initial begin
    logic [7:0] msg[$];
    logic [7:0] cmd0[$];
    logic [7:0] cmd8[$];
    int         w;

    tbl[0].b = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00}; tbl[0].exp = 16'h4A;
    tbl[1].b = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA}; tbl[1].exp = 16'h43;
    tbl[2].b = '{8'h51, 8'h00, 8'h00, 8'h00, 8'h00}; tbl[2].exp = 16'h2A;
    tbl[3].b = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00}; tbl[3].exp = 16'h32;
    tbl[4].b = '{8'h69, 8'h40, 8'h00, 8'h00, 8'h00}; tbl[4].exp = 16'h3B;
    cmd0 = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
    cmd8 = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA};

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sel16 = 1'b0;
    #3;
    check_output("reset_crc_out",   32'(crc_s),       32'h0);
    check_output("reset_in_ready",  32'(in_ready_s),  32'd1);
    check_output("reset_busy",      32'(busy_s),      32'd0);
    check_output("reset_crc_valid", 32'(crc_valid_s), 32'd0);
    do_reset();

    // Known SD command vectors with a gap between words.
    for (int t = 0; t < 5; t++) begin
      msg.delete();
      for (int i = 0; i < 5; i++) msg.push_back(tbl[t].b[i]);
      vq.delete();
      send_msg(msg, 1'b1);
      wait_pulses(1);
      if (vq.size() > 0) check_output($sformatf("table%0d_crc", t), 32'(vq[0]), 32'(tbl[t].exp));
      check_output($sformatf("table%0d_hold", t), 32'(crc_s), 32'(tbl[t].exp));
`ifdef CRC_SD_TOKEN_EN
      check_output($sformatf("table%0d_token", t), 32'(token7), 32'({tbl[t].exp[6:0], 1'b1}));
`endif
    end

    // CMD0 then CMD8 with in_valid held: accept spacing and pulse latency.
    vq.delete(); vcyc.delete(); acc.delete();
    send_msg(cmd0, 1'b0);
    send_msg(cmd8, 1'b0);
    wait_pulses(2);
    if (vq.size() == 2) begin
      check_output("b2b_first_crc",  32'(vq[0]), 32'h4A);
      check_output("b2b_second_crc", 32'(vq[1]), 32'h43);
      check_output("b2b_first_latency",  32'(vcyc[0] - acc[4]), 32'd9);
      check_output("b2b_second_latency", 32'(vcyc[1] - acc[9]), 32'd9);
    end
    for (int i = 1; i < 10; i++)
      check_output($sformatf("accept_gap%0d", i), 32'(acc[i] - acc[i-1]), (i == 5) ? 32'd10 : 32'd9);

    // CRC16-CCITT over a 512-byte block of 0xFF.
    sel16 = 1'b1;
    do_reset();
    vq.delete();
    msg.delete();
    for (int i = 0; i < 512; i++) msg.push_back(8'hFF);
    send_msg(msg, 1'b0);
    wait_pulses(1);
    if (vq.size() > 0) check_output("crc16_block", 32'(vq[0]), 32'h7FA1);
    sel16 = 1'b0;

    // Abort in the 3rd SHIFT cycle of the 2nd CMD0 byte, then retry.
    vq.delete();
    apply_stimulus(8'h40, 1'b0);
    while (!in_ready_s) begin @(negedge clk); #1; end
    check_output("mid_msg_busy", 32'(busy_s), 32'd1);
    apply_stimulus(8'h00, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
    check_output("abort_busy", 32'(busy_s), 32'd0);
    check_output("abort_crc",  32'(crc_s),  32'h0);
    repeat (12) begin @(negedge clk); #1; end
    check_output("abort_no_pulse", 32'(vq.size()), 32'd0);
    send_msg(cmd0, 1'b0);
    wait_pulses(1);
    if (vq.size() > 0) check_output("abort_retry_crc", 32'(vq[0]), 32'h4A);

    // clear together with in_valid in IDLE: word refused.
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h40; in_last = 1'b0;
    #1;
    check_output("clear_blocks_ready", 32'(in_ready_s), 32'd0);
    @(negedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check_output("clear_not_accepted", 32'(busy_s), 32'd0);

    // Asynchronous reset mid-SHIFT takes effect without a clock edge.
    vq.delete();
    apply_stimulus(8'hFF, 1'b0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check_output("async_rst_crc",   32'(crc_s),      32'h0);
    check_output("async_rst_ready", 32'(in_ready_s), 32'd1);
    check_output("async_rst_busy",  32'(busy_s),     32'd0);
    #1;
    rst = 1'b0;
    @(negedge clk); #1;
    send_msg(cmd8, 1'b0);
    wait_pulses(1);
    if (vq.size() > 0) check_output("after_rst_crc", 32'(vq[0]), 32'h43);

    // Randomized messages on both widths against the division model.
    for (int r = 0; r < 16; r++) begin
      sel16 = 1'($urandom_range(0, 1));
      w = sel16 ? 16 : 7;
      msg.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) msg.push_back(8'($urandom));
      vq.delete();
      send_msg(msg, 1'($urandom_range(0, 1)));
      wait_pulses(1);
      if (vq.size() > 0)
        check_output($sformatf("random%0d_crc", r), 32'(vq[0]), 32'(model_crc(msg, w, sel16 ? 16'h1021 : 16'h0009)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
